// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
// Holds the sequencer state encoding and the default parameter values.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } ctrl_state_e;

    localparam int DEF_TIMEOUT = 64;
    localparam int DEF_CNT_W   = 16;

    // A MEM-stage instruction needs the SRAM when it is either a load or a store.
    function automatic logic mem_request(input logic r_en, input logic w_en);
        return r_en | w_en;
    endfunction

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Handshake bundle between the pipeline stages and the stall controller.
// The pipeline side is the master; the controller is the slave.
interface pipeline_stall_controller_if #(
    parameter int CNT_W = 16
);
    logic             hazard_detection;
    logic             branch_taken;
    logic             mem_r_en;
    logic             mem_w_en;
    logic             sram_ready;
    logic             freeze_all;
    logic             freeze_pc;
    logic             bubble_id_ex;
    logic             flush_if_id;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output hazard_detection, branch_taken, mem_r_en, mem_w_en, sram_ready,
        input  freeze_all, freeze_pc, bubble_id_ex, flush_if_id, mem_timeout,
        input  stall_cycles, flush_count
    );

    modport slave (
        input  hazard_detection, branch_taken, mem_r_en, mem_w_en, sram_ready,
        output freeze_all, freeze_pc, bubble_id_ex, flush_if_id, mem_timeout,
        output stall_cycles, flush_count
    );
endinterface

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    // Next count: advance only when requested and not yet saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline: SRAM wait FSM with
// watchdog, hazard/branch priority resolution and saturating perf counters.
module pipeline_stall_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                        clk,
    input  logic                        rst,
    pipeline_stall_controller_if.slave  bus
);
    // Wide enough to hold TIMEOUT-1 with headroom.
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    ctrl_state_e       state_d;
    ctrl_state_e       state_q;
    logic [WAIT_W-1:0] wait_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q;

    logic              mem_req_s;
    logic              freeze_all_s;
    logic              freeze_pc_s;
    logic              bubble_id_ex_s;
    logic              flush_if_id_s;
    logic              mem_timeout_s;
    logic              stall_inc_s;
    logic [CNT_W-1:0]  stall_cycles_s;
    logic [CNT_W-1:0]  flush_count_s;

    assign mem_req_s = mem_request(bus.mem_r_en, bus.mem_w_en);

    // SRAM wait FSM: next state, wait counter and the global hold.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        freeze_all_s  = 1'b0;
        mem_timeout_s = 1'b0;
        case (state_q)
            RUN: begin
                if (mem_req_s && !bus.sram_ready) begin
                    freeze_all_s = 1'b1;
                    state_d      = MEM_WAIT;
                    wait_cnt_d   = {{(WAIT_W-1){1'b0}}, 1'b1};
                end else begin
                    wait_cnt_d   = {WAIT_W{1'b0}};
                end
            end
            MEM_WAIT: begin
                if (bus.sram_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = {WAIT_W{1'b0}};
                end else begin
                    freeze_all_s = 1'b1;
                    if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
                        state_d = FAULT;
                    end else begin
                        wait_cnt_d = wait_cnt_q + {{(WAIT_W-1){1'b0}}, 1'b1};
                    end
                end
            end
            FAULT: begin
                freeze_all_s  = 1'b1;
                mem_timeout_s = 1'b1;
            end
            default: begin
                // Unreachable encoding: hold the pipeline and resynchronise.
                freeze_all_s = 1'b1;
                state_d      = RUN;
                wait_cnt_d   = {WAIT_W{1'b0}};
            end
        endcase
    end

    // Stage modifications; a global hold suppresses all of them, and a taken
    // branch beats a hazard because the hazarding instruction is squashed.
    always_comb begin
        freeze_pc_s    = 1'b0;
        bubble_id_ex_s = 1'b0;
        flush_if_id_s  = 1'b0;
        if (freeze_all_s) begin
            freeze_pc_s    = 1'b0;
            bubble_id_ex_s = 1'b0;
            flush_if_id_s  = 1'b0;
        end else if (bus.branch_taken) begin
            flush_if_id_s  = 1'b1;
            bubble_id_ex_s = 1'b1;
        end else if (bus.hazard_detection) begin
            freeze_pc_s    = 1'b1;
            bubble_id_ex_s = 1'b1;
        end else begin
            freeze_pc_s    = 1'b0;
        end
    end

    // The permanent fault freeze is not a performance stall.
    always_comb begin
        stall_inc_s = 1'b0;
        if (state_q != FAULT) begin
            stall_inc_s = freeze_all_s | freeze_pc_s;
        end else begin
            stall_inc_s = 1'b0;
        end
    end

    // FSM state and wait counter registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= RUN;
            wait_cnt_q <= {WAIT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc_s),
        .cnt (stall_cycles_s)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_if_id_s),
        .cnt (flush_count_s)
    );

    assign bus.freeze_all   = freeze_all_s;
    assign bus.freeze_pc    = freeze_pc_s;
    assign bus.bubble_id_ex = bubble_id_ex_s;
    assign bus.flush_if_id  = flush_if_id_s;
    assign bus.mem_timeout  = mem_timeout_s;
    assign bus.stall_cycles = stall_cycles_s;
    assign bus.flush_count  = flush_count_s;
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed plus randomised bench for pipeline_stall_controller against a
// behavioural model that tracks frozen-cycle run length and counter totals.
module tb_pipeline_stall_controller;
    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipeline_stall_controller_if #(.CNT_W(CNT_W)) bus ();

    pipeline_stall_controller #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: length of the current frozen memory access, fault flag, totals.
    int   m_frozen = 0;
    bit   m_fault  = 1'b0;
    int   m_stall  = 0;
    int   m_flush  = 0;
    logic e_fa, e_fp, e_bub, e_fl;

    function void model_outs();
        logic req;
        req = bus.mem_r_en | bus.mem_w_en;
        if (m_fault)           e_fa = 1'b1;
        else if (m_frozen > 0) e_fa = !bus.sram_ready;
        else                   e_fa = req && !bus.sram_ready;
        e_fl  = !e_fa && bus.branch_taken;
        e_bub = !e_fa && (bus.branch_taken || bus.hazard_detection);
        e_fp  = !e_fa && !bus.branch_taken && bus.hazard_detection;
    endfunction

    function void model_update();
        if (!rst) begin
            m_frozen = 0; m_fault = 1'b0; m_stall = 0; m_flush = 0;
        end else begin
            if ((e_fa || e_fp) && !m_fault && m_stall < CNT_MAX) m_stall++;
            if (e_fl && m_flush < CNT_MAX) m_flush++;
            if (!m_fault) begin
                if (e_fa) begin
                    m_frozen++;
                    if (m_frozen == TIMEOUT) m_fault = 1'b1;
                end else begin
                    m_frozen = 0;
                end
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic h, input logic b, input logic r, input logic w, input logic s);
        bus.hazard_detection = h;
        bus.branch_taken     = b;
        bus.mem_r_en         = r;
        bus.mem_w_en         = w;
        bus.sram_ready       = s;
    endtask

    task automatic step();
        #4;
        model_outs();
        chk("freeze_all",   32'(bus.freeze_all),   32'(e_fa));
        chk("freeze_pc",    32'(bus.freeze_pc),    32'(e_fp));
        chk("bubble_id_ex", 32'(bus.bubble_id_ex), 32'(e_bub));
        chk("flush_if_id",  32'(bus.flush_if_id),  32'(e_fl));
        chk("mem_timeout",  32'(bus.mem_timeout),  32'(m_fault));
        chk("stall_cycles", 32'(bus.stall_cycles), 32'(m_stall));
        chk("flush_count",  32'(bus.flush_count),  32'(m_flush));
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        model_update();
        #1;
        step();
        rst = 1'b1;

        // Hazard held for three cycles.
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) step();
        chk("stall_after_hazard", 32'(bus.stall_cycles), 32'd3);
        chk("flush_after_hazard", 32'(bus.flush_count), 32'd0);

        // Branch wins over a simultaneous hazard.
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk("flush_after_branch", 32'(bus.flush_count), 32'd1);

        // Reset in the middle of an SRAM wait.
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (5) step();
        rst = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("stall_after_reset", 32'(bus.stall_cycles), 32'd0);

        // Four-cycle SRAM wait; branches during the freeze must not flush.
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (4) step();
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("stall_after_wait", 32'(bus.stall_cycles), 32'd4);
        chk("flush_after_wait", 32'(bus.flush_count), 32'd0);

        // Watchdog: store that never completes.
        rst = 1'b0;
        step();
        rst = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (TIMEOUT) step();
        #4;
        chk("timeout_flag", 32'(bus.mem_timeout), 32'd1);
        chk("timeout_freeze", 32'(bus.freeze_all), 32'd1);
        chk("timeout_stall", 32'(bus.stall_cycles), 32'd8);
        @(posedge clk);
        model_update();
        #1;
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (4) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("fault_cleared", 32'(bus.mem_timeout), 32'd0);

        // Counter saturation.
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (20) step();
        chk("stall_saturated", 32'(bus.stall_cycles), 32'd15);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) != 0);
            set_in(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                   ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
                   ($urandom_range(0, 9) < 6));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Consumes the ID-stage hazard_detection flag, the EX-stage branch-taken signal and the MEM-stage SRAM handshake.
- Produces the PC/IF-ID freeze, the ID-EX bubble, the IF-ID flush and the global freeze.
- Tracks SRAM wait with an FSM and timeout watchdog, and keeps saturating performance counters.

Parameters:
- TIMEOUT, 64, max consecutive SRAM wait cycles before the fault state (must be >= 2).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous reset, active-low (asserted when 0, sampled on rising clk).
- hazard_detection  in  1  ID-stage data hazard, needs a stall.
- branch_taken  in  1  EX-stage branch/jump resolved taken.
- mem_r_en  in  1  MEM-stage load.
- mem_w_en  in  1  MEM-stage store.
- sram_ready  in  1  SRAM access complete this cycle.
- freeze_all  out  1  hold every pipeline register and the PC.
- freeze_pc  out  1  hold the PC and the IF-ID register.
- bubble_id_ex  out  1  load a NOP (all control zero) into ID-EX.
- flush_if_id  out  1  replace IF-ID with a NOP.
- mem_timeout  out  1  sticky SRAM watchdog fault.
- stall_cycles  out  CNT_W  cycles with freeze_all or freeze_pc high.
- flush_count  out  CNT_W  number of branch flushes.

Behaviour:
- States: RUN, MEM_WAIT, FAULT. Encoding goes in the package.
- Reset (rst=0 at an edge): state<=RUN, wait_cnt<=0, counters<=0, mem_timeout<=0. Reset overrides every state, including mid-MEM_WAIT and FAULT.
- Outputs are combinational from state and inputs. After reset, all outputs are 0 unless the inputs request otherwise.
- mem_req = mem_r_en | mem_w_en.
- RUN:
  - mem_req & !sram_ready: freeze_all=1 this cycle, next state MEM_WAIT, wait_cnt<=1.
  - mem_req & sram_ready: single-cycle access, no freeze, stay in RUN.
- MEM_WAIT:
  - freeze_all = !sram_ready.
  - sram_ready=1: freeze_all=0 in that same cycle, next state RUN, wait_cnt<=0.
  - Otherwise wait_cnt++. If wait_cnt==TIMEOUT-1 while still not ready, next state FAULT.
  - Inputs other than sram_ready are ignored, because the pipeline is frozen.
- FAULT: freeze_all=1 and mem_timeout=1 permanently. Exit only by reset.
- Priority when freeze_all=0, branch first:
  - branch_taken=1: flush_if_id=1, bubble_id_ex=1, freeze_pc=0. The branch wins over a hazard, since the hazarding instruction is squashed.
  - else hazard_detection=1: freeze_pc=1, bubble_id_ex=1, flush_if_id=0.
  - else all three are 0.
- When freeze_all=1, freeze_pc, bubble_id_ex and flush_if_id are all forced to 0. Hold has priority over every modification.
- stall_cycles increments on each clk with (freeze_all | freeze_pc) in RUN or MEM_WAIT. It does not count in FAULT.
- flush_count increments on each clk with flush_if_id=1.
- Both counters saturate at all-ones and never wrap.
- Every cycle counts regardless of back-to-back events: a hazard held for N cycles adds N to stall_cycles.
- There is no combinational path from sram_ready to state other than through the next-state logic. Outputs contain no latches.

Decomposition:
- Package pipeline_ctrl_pkg holds the state enum (RUN=2'd0, MEM_WAIT=2'd1, FAULT=2'd2) and the default values of TIMEOUT and CNT_W.
- One natural sub-module: sat_counter (parameter W; inputs clk, rst, inc; output cnt). It is instantiated twice for stall_cycles and flush_count.

Test Plan:
- Reset: rst=0 for 2 cycles while in MEM_WAIT with wait_cnt=5 -> state RUN, all outputs 0, counters 0.
- Hazard: hazard_detection=1 for 3 cycles, no branch/mem -> freeze_pc=1 and bubble_id_ex=1 each cycle, stall_cycles=3, flush_count=0.
- Branch and hazard together: branch_taken=1, hazard_detection=1 for 1 cycle -> flush_if_id=1, bubble_id_ex=1, freeze_pc=0, flush_count=1.
- SRAM wait: mem_r_en=1 with sram_ready low for 4 cycles, then high -> freeze_all=1 for 4 cycles and 0 on the ready cycle. Branch_taken=1 during the wait gives no flush. State returns to RUN, stall_cycles=4.
- Timeout (TIMEOUT=8): mem_w_en=1, sram_ready=0 forever -> FAULT entered after 8 frozen cycles, mem_timeout=1, freeze_all stuck at 1. Late sram_ready=1 has no effect; rst=0 clears the fault.
- Saturation (CNT_W=4): hazard held for 20 cycles -> stall_cycles reaches 15 and stays at 15.
